// File: rtl/snitch_icache_pkg.sv
// Shared configuration, tag-entry layout and controller state encoding for the
// instruction-cache tag path.
package snitch_icache_pkg;

  typedef struct packed {
    int unsigned WAY_COUNT;
    int unsigned LINE_COUNT;
    int unsigned COUNT_ALIGN;
    int unsigned TAG_WIDTH;
  } config_t;

  localparam config_t DEFAULT_CFG = '{
    WAY_COUNT:   32'd4,
    LINE_COUNT:  32'd128,
    COUNT_ALIGN: 32'd7,
    TAG_WIDTH:   32'd20
  };

  // Bit offsets above the tag field inside one way-entry.
  localparam int unsigned TAG_ERR_BIT   = 0;
  localparam int unsigned TAG_VALID_BIT = 1;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } tag_ctrl_state_e;

endpackage

// File: rtl/snitch_icache_tag_cmp.sv
// Per-way tag comparison on a full line read from the tag SRAM: raw hit vector
// plus the OR of the error flags of every hitting way.
module snitch_icache_tag_cmp
  import snitch_icache_pkg::*;
#(
  parameter config_t CFG = DEFAULT_CFG
) (
  input  logic [CFG.WAY_COUNT*(CFG.TAG_WIDTH+2)-1:0] rdata_i,
  input  logic [CFG.TAG_WIDTH-1:0]                   tag_i,
  output logic [CFG.WAY_COUNT-1:0]                   hit_o,
  output logic                                       err_o
);

  localparam int unsigned WAYS = CFG.WAY_COUNT;
  localparam int unsigned TW   = CFG.TAG_WIDTH;
  localparam int unsigned EW   = TW + 2;

  logic [WAYS-1:0] err_vec;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [EW-1:0] entry;
    assign entry      = rdata_i[w*EW +: EW];
    assign hit_o[w]   = entry[TW+TAG_VALID_BIT] && (entry[TW-1:0] == tag_i);
    assign err_vec[w] = entry[TW+TAG_ERR_BIT];
  end

  assign err_o = |(hit_o & err_vec);

endmodule

// File: rtl/snitch_icache_tag_ctrl.sv
// Tag SRAM sequencer: invalidation sweep after reset/flush, then arbitrates the
// single port between flush, refill writes and lookups (in that priority).
module snitch_icache_tag_ctrl
  import snitch_icache_pkg::*;
#(
  parameter config_t     CFG       = DEFAULT_CFG,
  parameter int unsigned WAY_IDX_W = $clog2(CFG.WAY_COUNT)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       flush_valid_i,
  output logic                                       flush_ready_o,
  output logic                                       busy_o,
  input  logic                                       lookup_valid_i,
  output logic                                       lookup_ready_o,
  input  logic [CFG.COUNT_ALIGN-1:0]                 lookup_addr_i,
  input  logic [CFG.TAG_WIDTH-1:0]                   lookup_tag_i,
  output logic                                       lookup_rsp_valid_o,
  output logic [CFG.WAY_COUNT-1:0]                   lookup_rsp_hit_o,
  output logic                                       lookup_rsp_err_o,
  input  logic                                       write_valid_i,
  output logic                                       write_ready_o,
  input  logic [CFG.COUNT_ALIGN-1:0]                 write_addr_i,
  input  logic [WAY_IDX_W-1:0]                       write_way_i,
  input  logic [CFG.TAG_WIDTH-1:0]                   write_tag_i,
  input  logic                                       write_err_i,
  output logic                                       sram_req_o,
  output logic                                       sram_write_o,
  output logic [CFG.COUNT_ALIGN-1:0]                 sram_addr_o,
  output logic [CFG.WAY_COUNT*(CFG.TAG_WIDTH+2)-1:0] sram_wdata_o,
  output logic [CFG.WAY_COUNT-1:0]                   sram_be_o,
  input  logic [CFG.WAY_COUNT*(CFG.TAG_WIDTH+2)-1:0] sram_rdata_i
);

  localparam int unsigned WAYS = CFG.WAY_COUNT;
  localparam int unsigned TW   = CFG.TAG_WIDTH;
  localparam int unsigned EW   = TW + 2;
  localparam int unsigned CA   = CFG.COUNT_ALIGN;
  localparam logic [CA-1:0] CNT_LAST = CA'(CFG.LINE_COUNT - 1);

  tag_ctrl_state_e state_q, state_d;
  logic [CA-1:0]   cnt_q, cnt_d;
  logic            sweep_last;
  logic [EW-1:0]   wentry;

  logic            vld_p1;
  logic [TW-1:0]   tag_p1;
  logic [WAYS-1:0] hit_raw;
  logic            err_raw;

  assign sweep_last = (state_q == SWEEP) && (cnt_q == CNT_LAST);

  always_comb begin
    wentry                   = '0;
    wentry[TW+TAG_VALID_BIT] = 1'b1;
    wentry[TW+TAG_ERR_BIT]   = write_err_i;
    wentry[TW-1:0]           = write_tag_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SWEEP: begin
        if (sweep_last) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CA'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        if (flush_valid_i) state_d = SWEEP;
      end
      default: ;
    endcase
  end

  // A flush cycle in RUN leaves the port idle; the sweep starts next cycle.
  always_comb begin
    sram_req_o     = 1'b0;
    sram_write_o   = 1'b0;
    sram_addr_o    = '0;
    sram_wdata_o   = '0;
    sram_be_o      = '0;
    busy_o         = 1'b0;
    flush_ready_o  = 1'b0;
    lookup_ready_o = 1'b0;
    write_ready_o  = 1'b0;
    unique case (state_q)
      SWEEP: begin
        busy_o        = 1'b1;
        sram_req_o    = 1'b1;
        sram_write_o  = 1'b1;
        sram_addr_o   = cnt_q;
        sram_be_o     = '1;
        flush_ready_o = flush_valid_i && sweep_last;
      end
      RUN: begin
        if (!flush_valid_i) begin
          if (write_valid_i) begin
            sram_req_o    = 1'b1;
            sram_write_o  = 1'b1;
            sram_addr_o   = write_addr_i;
            sram_wdata_o  = {WAYS{wentry}};
            sram_be_o     = WAYS'(1) << write_way_i;
            write_ready_o = 1'b1;
          end else if (lookup_valid_i) begin
            sram_req_o     = 1'b1;
            sram_addr_o    = lookup_addr_i;
            lookup_ready_o = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // p0 -> p1: lookup accepted, read in flight; compare on returned line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) vld_p1 <= 1'b0;
    else       vld_p1 <= lookup_ready_o;
  end

  always_ff @(posedge clk_i) begin
    if (lookup_ready_o) tag_p1 <= lookup_tag_i;
  end

  snitch_icache_tag_cmp #(
    .CFG (CFG)
  ) i_tag_cmp (
    .rdata_i (sram_rdata_i),
    .tag_i   (tag_p1),
    .hit_o   (hit_raw),
    .err_o   (err_raw)
  );

  assign lookup_rsp_valid_o = vld_p1;
  assign lookup_rsp_hit_o   = vld_p1 ? hit_raw : '0;
  assign lookup_rsp_err_o   = vld_p1 && err_raw;

endmodule

// File: tb/tb_snitch_icache_tag_ctrl.sv
// Directed bench for the tag controller: SRAM model, per-cycle reference check
// of port/response behaviour, and literal expectations for key scenarios.
module tb_snitch_icache_tag_ctrl;

  localparam int LINES = 128;
  localparam int WAYS  = 4;
  localparam int TW    = 20;
  localparam int EW    = TW + 2;
  localparam int CA    = 7;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 flush_valid_i = 1'b0;
  logic                 flush_ready_o;
  logic                 busy_o;
  logic                 lookup_valid_i = 1'b0;
  logic                 lookup_ready_o;
  logic [CA-1:0]        lookup_addr_i = '0;
  logic [TW-1:0]        lookup_tag_i = '0;
  logic                 lookup_rsp_valid_o;
  logic [WAYS-1:0]      lookup_rsp_hit_o;
  logic                 lookup_rsp_err_o;
  logic                 write_valid_i = 1'b0;
  logic                 write_ready_o;
  logic [CA-1:0]        write_addr_i = '0;
  logic [1:0]           write_way_i = '0;
  logic [TW-1:0]        write_tag_i = '0;
  logic                 write_err_i = 1'b0;
  logic                 sram_req_o;
  logic                 sram_write_o;
  logic [CA-1:0]        sram_addr_o;
  logic [WAYS*EW-1:0]   sram_wdata_o;
  logic [WAYS-1:0]      sram_be_o;
  logic [WAYS*EW-1:0]   sram_rdata_i = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  snitch_icache_tag_ctrl dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .flush_valid_i      (flush_valid_i),
    .flush_ready_o      (flush_ready_o),
    .busy_o             (busy_o),
    .lookup_valid_i     (lookup_valid_i),
    .lookup_ready_o     (lookup_ready_o),
    .lookup_addr_i      (lookup_addr_i),
    .lookup_tag_i       (lookup_tag_i),
    .lookup_rsp_valid_o (lookup_rsp_valid_o),
    .lookup_rsp_hit_o   (lookup_rsp_hit_o),
    .lookup_rsp_err_o   (lookup_rsp_err_o),
    .write_valid_i      (write_valid_i),
    .write_ready_o      (write_ready_o),
    .write_addr_i       (write_addr_i),
    .write_way_i        (write_way_i),
    .write_tag_i        (write_tag_i),
    .write_err_i        (write_err_i),
    .sram_req_o         (sram_req_o),
    .sram_write_o       (sram_write_o),
    .sram_addr_o        (sram_addr_o),
    .sram_wdata_o       (sram_wdata_o),
    .sram_be_o          (sram_be_o),
    .sram_rdata_i       (sram_rdata_i)
  );

  // Tag SRAM: byte-enabled writes, read data one cycle after the request.
  logic [WAYS*EW-1:0] mem [LINES];
  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_write_o) begin
        for (int w = 0; w < WAYS; w++)
          if (sram_be_o[w]) mem[sram_addr_o][w*EW +: EW] <= sram_wdata_o[w*EW +: EW];
      end else begin
        sram_rdata_i <= mem[sram_addr_o];
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: cache contents as a plain table, sweep as a countdown.
  bit              mv [LINES][WAYS];
  logic [TW-1:0]   mt [LINES][WAYS];
  bit              me [LINES][WAYS];
  int              sweep_left;
  bit              pend, grant;
  logic [WAYS-1:0] pend_hit, nh;
  bit              pend_err, ne;
  logic            e_req, e_wr, e_lr, e_wrdy, e_fr, e_busy, chk_data;
  logic [CA-1:0]   e_addr;
  logic [WAYS*EW-1:0] e_wd;
  logic [WAYS-1:0] e_be;

  always @(negedge clk_i) begin
    if (rst_i) begin
      sweep_left = LINES;
      pend = 0;
      for (int l = 0; l < LINES; l++) for (int w = 0; w < WAYS; w++) mv[l][w] = 0;
    end else begin
      e_req = 0; e_wr = 0; e_addr = '0; e_wd = '0; e_be = '0;
      e_lr = 0; e_wrdy = 0; e_fr = 0; grant = 0; chk_data = 1;
      nh = '0; ne = 0;
      e_busy = (sweep_left > 0);
      if (sweep_left > 0) begin
        e_req = 1; e_wr = 1; e_be = 4'hf;
        e_addr = CA'(LINES - sweep_left);
        e_fr = flush_valid_i && (sweep_left == 1);
        sweep_left--;
      end else if (flush_valid_i) begin
        sweep_left = LINES;
        for (int l = 0; l < LINES; l++) for (int w = 0; w < WAYS; w++) mv[l][w] = 0;
      end else if (write_valid_i) begin
        e_req = 1; e_wr = 1; e_wrdy = 1;
        e_addr = write_addr_i;
        e_be = 4'b0001 << write_way_i;
        for (int w = 0; w < WAYS; w++) e_wd[w*EW +: EW] = {1'b1, write_err_i, write_tag_i};
        mv[write_addr_i][write_way_i] = 1;
        mt[write_addr_i][write_way_i] = write_tag_i;
        me[write_addr_i][write_way_i] = write_err_i;
      end else if (lookup_valid_i) begin
        e_req = 1; e_lr = 1; grant = 1; chk_data = 0;
        e_addr = lookup_addr_i;
        for (int w = 0; w < WAYS; w++)
          if (mv[lookup_addr_i][w] && mt[lookup_addr_i][w] == lookup_tag_i) begin
            nh[w] = 1'b1;
            if (me[lookup_addr_i][w]) ne = 1;
          end
      end
      chk("busy", busy_o, e_busy);
      chk("sram_req", sram_req_o, e_req);
      chk("sram_write", sram_write_o, e_wr);
      chk("sram_addr", sram_addr_o, e_addr);
      chk("lookup_ready", lookup_ready_o, e_lr);
      chk("write_ready", write_ready_o, e_wrdy);
      chk("flush_ready", flush_ready_o, e_fr);
      if (chk_data) begin
        chk("sram_wdata", sram_wdata_o, e_wd);
        chk("sram_be", sram_be_o, e_be);
      end
      chk("rsp_valid", lookup_rsp_valid_o, pend);
      if (pend) begin
        chk("rsp_hit", lookup_rsp_hit_o, pend_hit);
        chk("rsp_err", lookup_rsp_err_o, pend_err);
      end
      pend = grant;
      pend_hit = nh;
      pend_err = ne;
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input int a, input int w, input logic [TW-1:0] t, input logic e);
    write_valid_i = 1; write_addr_i = CA'(a); write_way_i = 2'(w);
    write_tag_i = t; write_err_i = e;
    cyc();
    write_valid_i = 0;
  endtask

  task automatic do_lookup(input int a, input logic [TW-1:0] t);
    lookup_valid_i = 1; lookup_addr_i = CA'(a); lookup_tag_i = t;
    cyc();
    lookup_valid_i = 0;
  endtask

  task automatic count_sweep(input string name);
    int n;
    n = 0;
    while (n < 300) begin
      @(negedge clk_i);
      if (!busy_o) break;
      n++;
    end
    chk(name, n, 128);
    cyc();
  endtask

  task automatic lit_rsp(input string name, input logic [WAYS-1:0] h, input logic e);
    chk({name, "_valid"}, lookup_rsp_valid_o, 1'b1);
    chk({name, "_hit"}, lookup_rsp_hit_o, h);
    chk({name, "_err"}, lookup_rsp_err_o, e);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_busy", busy_o, 1'b1);
    chk("rst_rsp_valid", lookup_rsp_valid_o, 1'b0);
    chk("rst_flush_ready", flush_ready_o, 1'b0);
    chk("rst_lookup_ready", lookup_ready_o, 1'b0);
    chk("rst_write_ready", write_ready_o, 1'b0);
    rst_i = 0;
    count_sweep("init_sweep_len");

    do_write(5, 2, 20'hABCDE, 0);
    do_lookup(5, 20'hABCDE);
    lit_rsp("l5_hit", 4'b0100, 0);
    do_lookup(5, 20'h12345);
    lit_rsp("l5_miss", 4'b0000, 0);
    do_write(9, 0, 20'h00777, 1);
    do_lookup(9, 20'h00777);
    lit_rsp("l9_err", 4'b0001, 1);

    // Write and lookup together: write wins, lookup follows.
    write_valid_i = 1; write_addr_i = 7'd20; write_way_i = 2'd3; write_tag_i = 20'h55555; write_err_i = 0;
    lookup_valid_i = 1; lookup_addr_i = 7'd20; lookup_tag_i = 20'h55555;
    #1;
    chk("arb_write_ready", write_ready_o, 1'b1);
    chk("arb_lookup_ready", lookup_ready_o, 1'b0);
    cyc();
    write_valid_i = 0;
    #1;
    chk("arb_lookup_next", lookup_ready_o, 1'b1);
    cyc();
    lookup_valid_i = 0;
    lit_rsp("raw_fwd", 4'b1000, 0);

    // Lookup then overwrite of the same line: response shows old entry.
    lookup_valid_i = 1; lookup_addr_i = 7'd20; lookup_tag_i = 20'h55555;
    cyc();
    lookup_valid_i = 0;
    write_valid_i = 1; write_addr_i = 7'd20; write_way_i = 2'd3; write_tag_i = 20'h66666;
    lit_rsp("war_old", 4'b1000, 0);
    cyc();
    write_valid_i = 0;
    do_lookup(20, 20'h66666);
    lit_rsp("war_new", 4'b1000, 0);
    do_lookup(20, 20'h55555);
    lit_rsp("war_gone", 4'b0000, 0);

    do_write(30, 0, 20'h0ABCD, 0);
    do_write(30, 1, 20'h0ABCD, 1);
    do_lookup(30, 20'h0ABCD);
    lit_rsp("multi_hit", 4'b0011, 1);

    // Flush with a response in flight.
    lookup_valid_i = 1; lookup_addr_i = 7'd5; lookup_tag_i = 20'hABCDE;
    cyc();
    lookup_valid_i = 0;
    flush_valid_i = 1;
    lit_rsp("flush_inflight", 4'b0100, 0);
    n = 0;
    while (n < 300) begin
      @(negedge clk_i);
      if (flush_ready_o) break;
      n++;
    end
    chk("flush_ready_delay", n, 128);
    cyc();
    flush_valid_i = 0;
    do_lookup(5, 20'hABCDE);
    lit_rsp("post_flush_l5", 4'b0000, 0);
    do_lookup(9, 20'h00777);
    lit_rsp("post_flush_l9", 4'b0000, 0);

    // Reset at sweep count 60.
    flush_valid_i = 1;
    cyc();
    flush_valid_i = 0;
    repeat (60) cyc();
    chk("sweep_at_60", sram_addr_o, 60);
    rst_i = 1;
    #1;
    chk("midsweep_rst_busy", busy_o, 1'b1);
    cyc();
    rst_i = 0;
    count_sweep("midsweep_rst_len");

    // Reset with a response pending drops it.
    do_write(40, 1, 20'h0F0F0, 0);
    do_lookup(40, 20'h0F0F0);
    lit_rsp("pre_rst_hit", 4'b0010, 0);
    rst_i = 1;
    #1;
    chk("rst_drop_rsp", lookup_rsp_valid_o, 1'b0);
    cyc();
    rst_i = 0;
    count_sweep("run_rst_len");
    do_lookup(40, 20'h0F0F0);
    lit_rsp("post_rst_l40", 4'b0000, 0);
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
